// File: rtl/uart_mem_loader.sv
// Serial program loader: receives a framed, checksummed image over 8N1 UART
// and streams it as packed big-endian words into a memory write port.
module uart_mem_loader #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned ADDR_WIDTH   = 12,
   parameter int unsigned BASE_ADDR    = 'h200,
   parameter int unsigned CLKS_PER_BIT = 104
) (
   input  logic                  clk,
   input  logic                  rstn_i,
   input  logic                  rs232_rx_i,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [DATA_WIDTH-1:0] d,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned             BPW       = DATA_WIDTH / 8;
   localparam int unsigned             CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]           BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]           HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [ADDR_WIDTH-1:0]   BASE      = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [15:0]             BPW16     = 16'(BPW);
   localparam logic [32:0]             MAX_WORDS = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);
   localparam int unsigned             WBW       = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [WBW-1:0]          WB_LAST   = WBW'(BPW - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

   rx_state_t r_rx_state;
   logic      r_sync_meta, r_sync, r_sync_d;
   logic [CW-1:0] r_clk_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_rx_shift;
   logic          r_rx_valid, r_rx_ferr;

   always_ff @(posedge clk) begin
      if (!rstn_i) begin
         r_rx_state  <= RX_IDLE;
         r_sync_meta <= 1'b1;
         r_sync      <= 1'b1;
         r_sync_d    <= 1'b1;
         r_clk_cnt   <= '0;
         r_bit_idx   <= '0;
         r_rx_shift  <= '0;
         r_rx_valid  <= 1'b0;
         r_rx_ferr   <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= so every flop sees pre-edge values, independent of statement order.
         r_sync_meta <= rs232_rx_i;
         r_sync      <= r_sync_meta;
         r_sync_d    <= r_sync;
         r_rx_valid  <= 1'b0;
         r_rx_ferr   <= 1'b0;
         case (r_rx_state)
            RX_IDLE: begin
               if (r_sync_d && !r_sync) begin
                  r_rx_state <= RX_START;
                  r_clk_cnt  <= '0;
               end
            end
            RX_START: begin
               if (r_clk_cnt == HALF_LAST) begin
                  r_clk_cnt  <= '0;
                  r_bit_idx  <= '0;
                  r_rx_state <= r_sync ? RX_IDLE : RX_DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (r_clk_cnt == BIT_LAST) begin
                  r_clk_cnt  <= '0;
                  r_rx_shift <= {r_sync, r_rx_shift[7:1]};
                  r_bit_idx  <= r_bit_idx + 1'b1;
                  if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (r_clk_cnt == BIT_LAST) begin
                  r_clk_cnt  <= '0;
                  r_rx_state <= RX_IDLE;
                  r_rx_valid <= r_sync;
                  r_rx_ferr  <= !r_sync;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

   state_t                r_state;
   logic [7:0]            r_len_hi;
   logic [15:0]           r_len, r_byte_cnt;
   logic [7:0]            r_sum;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [WBW-1:0]        r_wbyte;

   logic [15:0]           w_len;
   logic                  w_len_odd, w_len_big;
   logic [DATA_WIDTH-1:0] w_word;

   always_comb begin
      // NOTE: every signal here is assigned on every pass; a path that skipped one would infer a latch.
      w_len     = {r_len_hi, r_rx_shift};
      w_len_odd = (w_len % BPW16) != 16'd0;
      w_len_big = {17'd0, w_len / BPW16} > MAX_WORDS;
      w_word    = (r_shift << 8) | DATA_WIDTH'(r_rx_shift);
   end

   always_ff @(posedge clk) begin
      if (!rstn_i) begin
         r_state    <= S_IDLE;
         we         <= 1'b0;
         waddr      <= BASE;
         d          <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         r_len_hi   <= '0;
         r_len      <= '0;
         r_byte_cnt <= '0;
         r_sum      <= '0;
         r_shift    <= '0;
         r_wbyte    <= '0;
      end else begin
         we <= 1'b0;
         if (we) waddr <= waddr + 1'b1;
         // busy is high exactly in the states where a framing error aborts the load
         if (r_rx_ferr && busy) begin
            r_state <= S_ERR;
            busy    <= 1'b0;
            err     <= 1'b1;
         end else if (r_rx_valid) begin
            case (r_state)
               S_IDLE, S_DONE, S_ERR: begin
                  if (r_rx_shift == 8'hA5) begin
                     r_state    <= S_LEN_HI;
                     busy       <= 1'b1;
                     done       <= 1'b0;
                     err        <= 1'b0;
                     waddr      <= BASE;
                     r_byte_cnt <= '0;
                     r_sum      <= '0;
                     r_shift    <= '0;
                     r_wbyte    <= '0;
                  end
               end
               S_LEN_HI: begin
                  r_len_hi <= r_rx_shift;
                  r_state  <= S_LEN_LO;
               end
               S_LEN_LO: begin
                  r_len <= w_len;
                  if (w_len_odd || w_len_big) begin
                     r_state <= S_ERR;
                     busy    <= 1'b0;
                     err     <= 1'b1;
                  end else if (w_len == 16'd0) begin
                     r_state <= S_CSUM;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
               S_DATA: begin
                  r_sum      <= r_sum + r_rx_shift;
                  r_byte_cnt <= r_byte_cnt + 16'd1;
                  if (r_wbyte == WB_LAST) begin
                     we      <= 1'b1;
                     d       <= w_word;
                     r_shift <= '0;
                     r_wbyte <= '0;
                  end else begin
                     r_shift <= w_word;
                     r_wbyte <= r_wbyte + 1'b1;
                  end
                  if (r_byte_cnt + 16'd1 == r_len) r_state <= S_CSUM;
               end
               S_CSUM: begin
                  busy <= 1'b0;
                  if (r_rx_shift == r_sum) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                  end else begin
                     r_state <= S_ERR;
                     err     <= 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/uart_mem_loader.md
# uart_mem_loader

- Serial program loader for the chip8 platform.
- Receives 8N1 UART frames on `rs232_rx_i`, checks a framed and checksummed payload, and writes it into `mem` through that module's `we`/`waddr`/`d` write port, starting at a configurable base address.
- Holds `busy` high while a load is in progress, so the interpreter can be stalled and a new ROM loaded without resynthesis.
- Generalised in data width (packs several bytes per word), address width, base address and baud divisor.

## Interface
- `DATA_WIDTH`, 8: memory word width; must be a multiple of 8. `BPW = DATA_WIDTH/8` bytes per word.
- `ADDR_WIDTH`, 12: memory word-address width.
- `BASE_ADDR`, 12'h200: first word address written.
- `CLKS_PER_BIT`, 104: clock cycles per UART bit; must be ≥ 4.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rstn_i`, input, 1: reset, synchronous and active-low.
- `rs232_rx_i`, input, 1: asynchronous UART line, idle high.
- `we`, output, 1: one-cycle write strobe to `mem`.
- `waddr`, output, ADDR_WIDTH: write word address.
- `d`, output, DATA_WIDTH: write data.
- `busy`, output, 1: load in progress.
- `done`, output, 1: last frame completed with a good checksum.
- `err`, output, 1: last frame failed.

## Operation
- **RX front end**
  - `rs232_rx_i` passes through a 2-flop synchroniser.
  - Start is the synchronised falling edge while the receiver is idle.
  - Start bit is re-checked at `CLKS_PER_BIT/2`; if the line is high, the start is ignored.
  - Data bits are sampled LSB first at each bit centre, then the stop bit.
  - A stop bit of 0 is a framing error: the byte is discarded and the event is forwarded to the FSM.
  - A good byte produces a one-cycle internal `rx_valid` with `rx_byte`.
- **Frame format:** `0xA5`, `LEN_HI`, `LEN_LO`, then LEN payload bytes, then CSUM. CSUM is the sum of payload bytes mod 256.
- **FSM states:** IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
  - IDLE, DONE, ERR: on `rx_byte == 0xA5`, go to LEN_HI, clear `done`/`err`, set `busy`. Other bytes are ignored.
  - LEN_HI → LEN_LO on the next byte. LEN_LO latches the 16-bit length.
  - LEN_LO checks:
    - LEN mod BPW ≠ 0 → ERR.
    - LEN/BPW > 2^ADDR_WIDTH − BASE_ADDR → ERR.
    - LEN = 0 → CSUM.
    - Otherwise → DATA.
  - DATA:
    - Each byte is shifted into the word, big-endian (first byte into MSBs), and added to an 8-bit running sum.
    - When BPW bytes are collected, one write is issued and the word address increments.
    - After LEN bytes → CSUM.
  - CSUM: byte equal to the running sum → DONE (`done`=1), otherwise → ERR (`err`=1).
  - A framing error in any state other than IDLE/DONE/ERR → ERR.
- `busy` is 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 otherwise.
- `done` and `err` are sticky until the next `0xA5` header is accepted. They are never both 1.
- Words already written before a checksum or framing error stay in memory. There is no rollback.
- Reset mid-frame: FSM → IDLE, receiver → idle, partial word and sum discarded, no write issued.

## Timing
- Reset values: `we`=0, `waddr`=BASE_ADDR, `d`=0, `busy`=0, `done`=0, `err`=0. The internal byte counter, sum and shift register are 0.
- `rx_valid` fires in the cycle after the stop-bit sample.
- `we` rises in the cycle after the `rx_valid` that completes a word. `waddr`/`d` are valid in that same cycle.
- `waddr` increments in the cycle after `we` and is restored to BASE_ADDR on header accept.
- `busy` rises the cycle after the header's `rx_valid`. `busy` falls, and `done`/`err` rise, the cycle after the CSUM byte's `rx_valid`.
- Minimum spacing between `we` pulses is 10·CLKS_PER_BIT cycles.
- Length arithmetic is 16-bit unsigned. The address counter never wraps, because the range check rejects oversized frames.

## Test plan
- Use `CLKS_PER_BIT=4` for all scenarios.
- **Reset:** hold `rstn_i`=0 for 3 cycles with the line idle → all outputs at reset values, `waddr`=0x200.
- **8-bit frame:** `DATA_WIDTH=8`, send A5 00 02 12 34 46 → two `we` pulses, (0x200, 0x12) then (0x201, 0x34); `done`=1, `err`=0, `busy`=0.
- **16-bit packing:** `DATA_WIDTH=16`, send A5 00 04 AA BB CC DD 0E → writes (0x200, 0xAABB) then (0x201, 0xCCDD); `done`=1.
- **Bad checksum:** send A5 00 01 55 00 → one write (0x200, 0x55), then `err`=1, `done`=0; a following good frame clears `err`.
- **Length errors:** `DATA_WIDTH=16`, send A5 00 03 → `err`=1 after LEN_LO, no `we`. Separately, `DATA_WIDTH=8`, send A5 0E 01 → range error, no `we`.
- **Framing and reset:** stop bit forced 0 during a payload byte → `err`=1, IDLE, no write for that byte. Separately, `rstn_i` low mid-payload → no `we`, outputs at reset values, and the next full frame loads correctly.
